// File: rtl/vram_pkg.sv
// Shared constants for the VRAM write path: widths, FSM encoding and reader slot phases.
// The FILL state is used only when VRAM_WRITER_FILL_EN is defined.
package vram_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;

    // Phases 001 (address) and 011 (latch) belong to the display reader.
    localparam logic [2:0] PH_SLOT_A = 3'b101;
    localparam logic [2:0] PH_SLOT_B = 3'b110;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    function automatic logic slot_open(input logic border, input logic [2:0] phase);
        return border || (phase == PH_SLOT_A) || (phase == PH_SLOT_B);
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO buffering CPU writes; full is registered and reflects post-edge occupancy.
module vram_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 22
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic             do_push;
    logic             do_pop;

    // Push is qualified by the registered full flag, i.e. before any same-edge pop.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (PTR_W+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vram_writer.sv
// Arbitrates CPU writes into VRAM during display-reader idle slots via a small FIFO.
// Define VRAM_WRITER_FILL_EN to add the screen-fill engine (fill_req/fill_data/fill_busy).
module vram_writer
    import vram_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int VRAM_WORDS = 16384
) (
    input  logic              pixel_clock,
    input  logic              reset,
    input  logic              show_border,
    input  logic [2:0]        graph_phase,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
`ifdef VRAM_WRITER_FILL_EN
    input  logic              fill_req,
    input  logic [DATA_W-1:0] fill_data,
    output logic              fill_busy,
`endif
    output logic              fifo_full,
    output logic              wr_overflow,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    wr_entry_t  head;
    wr_entry_t  cpu_entry;
    logic       fifo_empty;
    logic       slot;
    logic       pop;

    assign cpu_entry = '{addr: cpu_addr, data: cpu_data};
    assign slot      = slot_open(show_border, graph_phase);
    assign pop       = (state == ST_DRAIN) && slot && !fifo_empty;

    vram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(wr_entry_t))
    ) u_fifo (
        .clk   (pixel_clock),
        .rst_n (reset),
        .push  (cpu_wr),
        .pop   (pop),
        .din   (cpu_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef VRAM_WRITER_FILL_EN
    logic [DATA_W-1:0] fill_val;
    logic [ADDR_W:0]   fill_addr;
    logic              fill_done;
    logic              fill_wr;

    assign fill_done = (fill_addr == (ADDR_W+1)'(VRAM_WORDS));
    assign fill_wr   = (state == ST_FILL) && slot && !fill_done;

    // fill_busy doubles as the pending-fill flag; it clears as FILL hands back to IDLE.
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            fill_busy <= 1'b0;
            fill_val  <= '0;
            fill_addr <= '0;
        end else if (fill_req && !fill_busy) begin
            fill_busy <= 1'b1;
            fill_val  <= fill_data;
            fill_addr <= '0;
        end else if (state == ST_FILL) begin
            if (fill_done) begin
                fill_busy <= 1'b0;
            end else if (slot) begin
                fill_addr <= fill_addr + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ST_DRAIN;
                end
`ifdef VRAM_WRITER_FILL_EN
                else if (fill_busy) begin
                    state_nxt = ST_FILL;
                end
`endif
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_nxt = ST_IDLE;
`ifdef VRAM_WRITER_FILL_EN
                    if (fill_busy) state_nxt = ST_FILL;
`endif
                end
            end
`ifdef VRAM_WRITER_FILL_EN
            ST_FILL: begin
                if (fill_done) state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered SRAM port: strobe lasts one cycle, address/data hold between writes.
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            sram_we     <= 1'b0;
            sram_addr   <= '0;
            sram_wdata  <= '0;
            wr_overflow <= 1'b0;
        end else begin
            state   <= state_nxt;
            sram_we <= 1'b0;
            if (pop) begin
                sram_we    <= 1'b1;
                sram_addr  <= head.addr;
                sram_wdata <= head.data;
            end
`ifdef VRAM_WRITER_FILL_EN
            if (fill_wr) begin
                sram_we    <= 1'b1;
                sram_addr  <= fill_addr[ADDR_W-1:0];
                sram_wdata <= fill_val;
            end
`endif
            if (cpu_wr && fifo_full) wr_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vram_writer.sv
// Scoreboard bench for vram_writer: stimulus queues expected SRAM writes, a monitor checks them.
module tb_vram_writer;

    logic        pixel_clock = 1'b0;
    logic        reset;
    logic        show_border;
    logic [2:0]  graph_phase;
    logic        cpu_wr;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        fifo_full;
    logic        wr_overflow;
    logic        sram_we;
    logic [13:0] sram_addr;
    logic [7:0]  sram_wdata;
`ifdef VRAM_WRITER_FILL_EN
    logic        fill_req;
    logic [7:0]  fill_data;
    logic        fill_busy;
`endif

    int checks   = 0;
    int failures = 0;
    int wr_seen  = 0;
    logic [21:0] exp_q[$];

    logic       phase_free = 1'b0;
    logic [2:0] phase_cnt  = 3'd0;
    logic [2:0] phase_fix  = 3'd0;
    logic       slot_prev  = 1'b0;

    always #5 pixel_clock = ~pixel_clock;

    assign graph_phase = phase_free ? phase_cnt : phase_fix;

    always @(posedge pixel_clock) begin
        phase_cnt <= phase_cnt + 3'd1;
        slot_prev <= show_border || (graph_phase == 3'b101) || (graph_phase == 3'b110);
    end

    vram_writer #(
        .FIFO_DEPTH (4),
        .VRAM_WORDS (16)
    ) dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .show_border (show_border),
        .graph_phase (graph_phase),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
`ifdef VRAM_WRITER_FILL_EN
        .fill_req    (fill_req),
        .fill_data   (fill_data),
        .fill_busy   (fill_busy),
`endif
        .fifo_full   (fifo_full),
        .wr_overflow (wr_overflow),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every SRAM write must be in a slot and match the head of the expected queue.
    always @(negedge pixel_clock) begin
        if (reset === 1'b1 && sram_we === 1'b1) begin
            wr_seen++;
            chk("slot_gate", {31'd0, slot_prev}, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h/%h required=none", sram_addr, sram_wdata);
            end else begin
                chk("write_order", {10'd0, sram_addr, sram_wdata}, {10'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge pixel_clock);
        #1;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic load_four(input logic [13:0] base, input logic [7:0] dbase);
        for (int i = 0; i < 4; i++) begin
            cpu_wr   = 1'b1;
            cpu_addr = base + 14'(i);
            cpu_data = dbase + 8'(i);
            exp_q.push_back({base + 14'(i), dbase + 8'(i)});
            tick();
        end
        cpu_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen_before;
        reset       = 1'b0;
        show_border = 1'b0;
        cpu_wr      = 1'b0;
        cpu_addr    = '0;
        cpu_data    = '0;
`ifdef VRAM_WRITER_FILL_EN
        fill_req    = 1'b0;
        fill_data   = '0;
`endif
        tick();
        tick();
        chk("rst_we", {31'd0, sram_we}, 0);
        chk("rst_addr_data", {10'd0, sram_addr, sram_wdata}, 0);
        chk("rst_flags", {30'd0, fifo_full, wr_overflow}, 0);
`ifdef VRAM_WRITER_FILL_EN
        chk("rst_fill_busy", {31'd0, fill_busy}, 0);
`endif
        reset = 1'b1;
        tick();

        // Single write: push at edge 0, strobe visible in cycle 2 only.
        show_border = 1'b1;
        cpu_wr      = 1'b1;
        cpu_addr    = 14'h0123;
        cpu_data    = 8'hA5;
        exp_q.push_back({14'h0123, 8'hA5});
        tick();
        cpu_wr = 1'b0;
        @(negedge pixel_clock);
        chk("single_c0_we", {31'd0, sram_we}, 0);
        tick();
        @(negedge pixel_clock);
        chk("single_c1_we", {31'd0, sram_we}, 0);
        tick();
        @(negedge pixel_clock);
        chk("single_c2_we", {31'd0, sram_we}, 1);
        chk("single_c2_addr", {18'd0, sram_addr}, 32'h0123);
        chk("single_c2_data", {24'd0, sram_wdata}, 32'hA5);
        tick();
        @(negedge pixel_clock);
        chk("single_c3_we", {31'd0, sram_we}, 0);
        chk("single_hold", {10'd0, sram_addr, sram_wdata}, {10'd0, 14'h0123, 8'hA5});

        // Slot gating with the phase counter free-running.
        tick();
        show_border = 1'b0;
        phase_free  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_wr   = 1'b1;
            cpu_addr = 14'h0200 + 14'(i);
            cpu_data = 8'h30 + 8'(i);
            exp_q.push_back({14'h0200 + 14'(i), 8'h30 + 8'(i)});
            tick();
        end
        cpu_wr = 1'b0;
        seen_before = wr_seen;
        wait_drain("gate_drain", 40);
        chk("gate_count", wr_seen - seen_before, 3);

        // Overflow: reader owns every cycle at phase 010.
        phase_free = 1'b0;
        phase_fix  = 3'b010;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            cpu_wr   = 1'b1;
            cpu_addr = 14'h0100 + 14'(i);
            cpu_data = 8'h10 + 8'(i);
            if (i < 4) exp_q.push_back({14'h0100 + 14'(i), 8'h10 + 8'(i)});
            tick();
            if (i == 2) chk("ovf_not_full_3", {31'd0, fifo_full}, 0);
            if (i == 3) chk("ovf_full_4", {30'd0, fifo_full, wr_overflow}, 32'b10);
        end
        cpu_wr = 1'b0;
        chk("ovf_flag", {30'd0, fifo_full, wr_overflow}, 32'b11);
        repeat (4) tick();
        chk("ovf_blocked", {31'd0, sram_we}, 0);
        seen_before = wr_seen;
        show_border = 1'b1;
        wait_drain("ovf_drain", 20);
        repeat (4) tick();
        chk("ovf_emit_count", wr_seen - seen_before, 4);
        chk("ovf_sticky", {30'd0, fifo_full, wr_overflow}, 32'b01);

        // Reset abort in the middle of a drain burst.
        show_border = 1'b0;
        load_four(14'h0300, 8'h50);
        show_border = 1'b1;
        begin
            int n = 0;
            while (exp_q.size() > 2 && n < 30) begin
                tick();
                n++;
            end
        end
        chk("abort_progress", exp_q.size(), 2);
        reset = 1'b0;
        #1;
        chk("abort_we_now", {31'd0, sram_we}, 0);
        chk("abort_flags", {30'd0, fifo_full, wr_overflow}, 0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        seen_before = wr_seen;
        repeat (20) tick();
        chk("abort_no_writes", wr_seen - seen_before, 0);

`ifdef VRAM_WRITER_FILL_EN
        // Fill: 16 consecutive writes, CPU write queued during fill lands afterwards.
        fill_req  = 1'b1;
        fill_data = 8'h20;
        for (int i = 0; i < 16; i++) exp_q.push_back({14'(i), 8'h20});
        tick();
        fill_req = 1'b0;
        chk("fill_busy_rise", {31'd0, fill_busy}, 1);
        cpu_wr    = 1'b1;
        cpu_addr  = 14'h3ABC;
        cpu_data  = 8'h5A;
        fill_req  = 1'b1;
        fill_data = 8'h77;
        exp_q.push_back({14'h3ABC, 8'h5A});
        tick();
        cpu_wr   = 1'b0;
        fill_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            @(negedge pixel_clock);
            chk("fill_consecutive", {31'd0, sram_we}, 1);
        end
        chk("fill_busy_last", {31'd0, fill_busy}, 1);
        tick();
        @(negedge pixel_clock);
        chk("fill_busy_fall", {30'd0, fill_busy, sram_we}, 0);
        wait_drain("fill_cpu_after", 20);
`endif

        repeat (4) tick();
        chk("queue_empty_end", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
